// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data requester, memory and status signals of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    // master: the arbiter itself; slave: requesters plus memory
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one single-port memory; ARB_ROUND_ROBIN_EN selects round-robin
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t        state, state_nxt;
    logic          owner;          // 1: data port owns the transaction
    logic [7:0]    wait_cnt;
    logic          err_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          any_req;
    logic          pick_d;
    logic          timeout;
    logic [DW-1:0] capture;

    assign any_req = bus.if_req | bus.d_req;
    assign timeout = (wait_cnt == WAIT_LIMIT) && !bus.mem_rvalid;
    assign capture = bus.mem_rvalid ? bus.mem_rdata : '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // Reset value "fetch won last" lets data win the first contested arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b0;
        else if (state == IDLE && any_req)
            last_d <= pick_d;
    end

    assign pick_d = bus.d_req && (!bus.if_req || !last_d);
`else
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)                     state_nxt = ISSUE;
            ISSUE:   if (bus.mem_gnt)                 state_nxt = WAIT;
            WAIT:    if (bus.mem_rvalid || timeout)   state_nxt = RESP;
            RESP:                                     state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    owner   <= pick_d;
                    addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                    wdata_q <= pick_d ? bus.d_wdata : '0;
                    we_q    <= pick_d & bus.d_we;
                end
                ISSUE: if (bus.mem_gnt) wait_cnt <= '0;
                WAIT: begin
                    if (bus.mem_rvalid || timeout) begin
                        if (owner) d_rdata_q  <= capture;
                        else       if_rdata_q <= capture;
                        err_q <= timeout;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_req = 1'b0;
        bus.if_ack  = 1'b0;
        bus.d_ack   = 1'b0;
        case (state)
            ISSUE: bus.mem_req = 1'b1;
            RESP: begin
                bus.if_ack = !owner;
                bus.d_ack  = owner;
            end
            default: ;
        endcase
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = bus.d_req & ~bus.d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (MAX_WAIT=4)
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic        stray;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_oth;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc = 0;
        bit   got = 0;
        int   ack_cyc = -1;
        bit   hold_ok = 1;
        bit   stall_ok = 1;
        bit   oth_ok = 1;
        logic ack, stall, exp_mreq;
        logic [31:0] rd = '0, oth_rd = '0;
        logic err_seen = 0;
        bus.if_req  = !v.is_d;
        bus.if_addr = v.addr;
        bus.d_req   = v.is_d;
        bus.d_we    = v.we;
        bus.d_addr  = v.addr;
        bus.d_wdata = v.wdata;
        while (!got && cyc < 40) begin
            bus.mem_gnt    = (cyc == 1 + v.gnt_dly);
            bus.mem_rvalid = (cyc == 2 + v.gnt_dly + v.rv_dly) || (v.stray && cyc == 1);
            bus.mem_rdata  = (cyc == 2 + v.gnt_dly + v.rv_dly) ? v.rdata : 32'hBAD0_BAD0;
            #1;
            exp_mreq = (cyc >= 1 && cyc <= 1 + v.gnt_dly);
            if (bus.mem_req !== exp_mreq) hold_ok = 0;
            if (exp_mreq && (bus.mem_addr !== v.addr || bus.mem_we !== (v.is_d & v.we) ||
                             (v.is_d && bus.mem_wdata !== v.wdata)))
                hold_ok = 0;
            ack   = v.is_d ? bus.d_ack : bus.if_ack;
            stall = v.is_d ? bus.stall_mem : bus.stall_if;
            if ((v.is_d ? bus.if_ack : bus.d_ack) !== 1'b0) oth_ok = 0;
            if (stall !== (ack !== 1'b1)) stall_ok = 0;
            if (ack === 1'b1) begin
                got = 1;
                ack_cyc = cyc;
                rd = v.is_d ? bus.d_rdata : bus.if_rdata;
                oth_rd = v.is_d ? bus.if_rdata : bus.d_rdata;
                err_seen = bus.err;
                bus.if_req = 0;
                bus.d_req = 0;
            end
            next_cycle();
            cyc++;
        end
        bus.mem_gnt = 0;
        bus.mem_rvalid = 0;
        #1;
        chk($sformatf("v%0d_ack_latency", idx), 64'(ack_cyc), 64'(v.exp_lat));
        chk($sformatf("v%0d_rdata", idx), {32'h0, rd}, {32'h0, v.exp_rdata});
        chk($sformatf("v%0d_err_with_ack", idx), {63'h0, err_seen}, {63'h0, v.exp_err});
        chk($sformatf("v%0d_other_rdata_held", idx), {32'h0, oth_rd}, {32'h0, v.exp_oth});
        chk($sformatf("v%0d_issue_hold", idx), {63'h0, hold_ok}, 64'h1);
        chk($sformatf("v%0d_stall", idx), {63'h0, stall_ok}, 64'h1);
        chk($sformatf("v%0d_other_ack_zero", idx), {63'h0, oth_ok}, 64'h1);
        chk($sformatf("v%0d_after_ack_idle", idx),
            {60'h0, bus.if_ack, bus.d_ack, bus.err, bus.mem_req}, 64'h0);
    endtask

    initial begin : main
        int   cyc;
        logic [3:0] order;
        logic [3:0] exp_order;
        int   n_won;
        bit   rr_d, rr_f, quiet_ok;
        bit   d_done, f_done;
        int   d_cyc, f_cyc;
        logic [31:0] d_val, f_val;

        //        is_d we addr          wdata         g  r   stray rdata         lat exp_rdata     err exp_oth
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 0,  1'b0, 32'h00500093, 3, 32'h00500093, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        0, 0,  1'b0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0, 32'h00500093};
        vecs[2] = '{1'b1, 1'b1, 32'h200, 32'h12345678, 3, 0,  1'b0, 32'hCAFE0000, 6, 32'hCAFE0000, 1'b0, 32'h00500093};
        vecs[3] = '{1'b0, 1'b0, 32'h20,  32'h0,        1, 2,  1'b1, 32'h11112222, 6, 32'h11112222, 1'b0, 32'hCAFE0000};
        vecs[4] = '{1'b1, 1'b0, 32'h300, 32'h0,        0, 99, 1'b0, 32'h77777777, 7, 32'h0,        1'b1, 32'h11112222};
        vecs[5] = '{1'b0, 1'b0, 32'h24,  32'h0,        0, 4,  1'b0, 32'hA5A5A5A5, 7, 32'hA5A5A5A5, 1'b0, 32'h0};

        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3;
        chk("reset_outputs",
            {bus.mem_req, bus.mem_we, bus.if_ack, bus.d_ack, bus.err, 59'h0},
            64'h0);
        chk("reset_mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        chk("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'h0);
        @(posedge clk);
        #2;
        rst = 0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous load and fetch from reset: data served first, then fetch
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_req = 1;  bus.d_addr = 32'h100; bus.d_we = 0;
        bus.mem_gnt = 1; bus.mem_rvalid = 1;
        d_done = 0; f_done = 0; d_cyc = -1; f_cyc = -1; d_val = '0; f_val = '0;
        cyc = 0;
        while (!(d_done && f_done) && cyc < 30) begin
            bus.mem_rdata = (cyc < 4) ? 32'hDEADBEEF : 32'h00000013;
            #1;
            if (bus.d_ack === 1'b1) begin d_done = 1; d_cyc = cyc; d_val = bus.d_rdata; bus.d_req = 0; end
            if (bus.if_ack === 1'b1) begin f_done = 1; f_cyc = cyc; f_val = bus.if_rdata; bus.if_req = 0; end
            next_cycle();
            cyc++;
        end
        chk("both_d_ack_cycle", 64'(d_cyc), 64'd3);
        chk("both_d_rdata", {32'h0, d_val}, 64'hDEADBEEF);
        chk("both_if_ack_cycle", 64'(f_cyc), 64'd7);
        chk("both_if_rdata", {32'h0, f_val}, 64'h00000013);

        // Both requesters re-raise after every ack; four winners recorded (bit0 first, 1 = data)
        do_reset();
        bus.if_req = 1; bus.d_req = 1; bus.mem_gnt = 1; bus.mem_rvalid = 1;
        order = '0; n_won = 0; rr_d = 0; rr_f = 0; cyc = 0;
        while (n_won < 4 && cyc < 60) begin
            if (rr_d) begin bus.d_req = 1; rr_d = 0; end
            if (rr_f) begin bus.if_req = 1; rr_f = 0; end
            #1;
            if (bus.d_ack === 1'b1) begin order[n_won] = 1'b1; n_won++; bus.d_req = 0; rr_d = 1; end
            else if (bus.if_ack === 1'b1) begin order[n_won] = 1'b0; n_won++; bus.if_req = 0; rr_f = 1; end
            next_cycle();
            cyc++;
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        chk("grant_order", {60'h0, order}, {60'h0, exp_order});
        chk("grant_count", 64'(n_won), 64'd4);

        // Reset while waiting for memory, then a late rvalid must be ignored
        do_reset();
        bus.d_req = 1; bus.d_addr = 32'h300; bus.mem_gnt = 1;
        next_cycle();
        next_cycle();
        #1;
        rst = 1;
        bus.d_req = 0; bus.mem_gnt = 0;
        #1;
        chk("rst_in_wait_mem_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst_in_wait_mem_addr", {32'h0, bus.mem_addr}, 64'h0);
        next_cycle();
        rst = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hFEEDF00D;
        quiet_ok = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0 || bus.mem_req !== 1'b0 ||
                bus.err !== 1'b0 || bus.d_rdata !== 32'h0)
                quiet_ok = 0;
            next_cycle();
        end
        bus.mem_rvalid = 0;
        chk("late_rvalid_ignored", {63'h0, quiet_ok}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
